// File: rtl/game_pkg.sv
// Shared game constants: motion states, keyboard scan codes and screen size.
package game_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_t;

  localparam logic [7:0] KEY_A   = 8'h04;
  localparam logic [7:0] KEY_D   = 8'h07;
  localparam logic [7:0] KEY_W   = 8'h1a;
  localparam logic [7:0] KEY_KP4 = 8'h5c;
  localparam logic [7:0] KEY_KP6 = 8'h5e;
  localparam logic [7:0] KEY_KP8 = 8'h60;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/character_motion_if.sv
// Per-player bundle: filtered keycode and collision flags in, position/status out.
interface character_motion_if;
  logic [15:0] keycode_char;
  logic        blocked_left;
  logic        blocked_right;
  logic        on_ground;
  logic        hit_ceiling;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        facing;
  logic [1:0]  motion_state;
  logic        moving;

  modport master (
    output keycode_char, blocked_left, blocked_right, on_ground, hit_ceiling,
    input  pos_x, pos_y, facing, motion_state, moving
  );

  modport slave (
    input  keycode_char, blocked_left, blocked_right, on_ground, hit_ceiling,
    output pos_x, pos_y, facing, motion_state, moving
  );
endinterface

// File: rtl/frame_tick_sync.sv
// Brings an asynchronous frame strobe into the Clk domain and emits a
// one-cycle tick on its rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic async_in,
  output logic tick
);

  // [1:0] is the metastability pair; [3:2] delay the edge so the tick lands
  // in the cycle after the third sampling edge.
  logic [3:0] sync_q;
  logic [3:0] sync_d;

  always_comb begin
    sync_d = {sync_q[2:0], async_in};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign tick = sync_q[2] & ~sync_q[3];

endmodule

// File: rtl/character_motion.sv
// Per-player motion controller: once per frame tick, walks left/right with
// wall and screen clamps and runs the jump/fall physics.
//
//   state  | meaning
//   GROUND | standing; jump key launches, missing floor starts a fall
//   RISE   | moving up, decelerating by GRAVITY each frame
//   FALL   | moving down, accelerating up to VMAX_FALL
module character_motion
  import game_pkg::*;
#(
  parameter logic [7:0] LEFT_CODE  = KEY_A,
  parameter logic [7:0] RIGHT_CODE = KEY_D,
  parameter logic [7:0] UP_CODE    = KEY_W,
  parameter int         X_START    = 32,
  parameter int         Y_START    = 400,
  parameter int         X_STEP     = 2,
  parameter int         JUMP_V0    = 12,
  parameter int         GRAVITY    = 1,
  parameter int         VMAX_FALL  = 8,
  parameter int         X_MIN      = 16,
  parameter int         X_MAX      = 608,
  parameter int         Y_MAX      = 448
) (
  input logic               Clk,
  input logic               Reset_n,
  input logic               frame_clk,
  character_motion_if.slave mot
);

  localparam logic [1:0] ST_GROUND = GROUND;
  localparam logic [1:0] ST_RISE   = RISE;
  localparam logic [1:0] ST_FALL   = FALL;

  localparam logic signed [10:0] X_STEP_S  = 11'(X_STEP);
  localparam logic signed [10:0] X_MIN_S   = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S   = 11'(Y_MAX);
  localparam logic signed [10:0] GRAVITY_S = 11'(GRAVITY);
  localparam logic signed [10:0] VMAX_S    = 11'(VMAX_FALL);

  logic tick;

  frame_tick_sync u_tick (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .async_in (frame_clk),
    .tick     (tick)
  );

  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic signed [7:0] vy_q, vy_d;
  logic [1:0]        state_q, state_d;
  logic              facing_q, facing_d;
  logic              moving_q, moving_d;

  // Position math is done 11-bit signed so underflow below zero is visible.
  logic signed [10:0] x_left, x_right, vy_ext, vy_inc, y_sum;

  always_comb begin
    vy_ext  = {{3{vy_q[7]}}, vy_q};
    vy_inc  = vy_ext + GRAVITY_S;
    y_sum   = $signed({1'b0, pos_y_q}) + vy_ext;
    x_left  = $signed({1'b0, pos_x_q}) - X_STEP_S;
    x_right = $signed({1'b0, pos_x_q}) + X_STEP_S;

    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vy_d     = vy_q;
    state_d  = state_q;
    facing_d = facing_q;
    moving_d = moving_q;

    if (tick) begin
      moving_d = 1'b0;
      if (mot.keycode_char[7:0] == LEFT_CODE) begin
        facing_d = 1'b0;
        if (!mot.blocked_left) begin
          moving_d = 1'b1;
          pos_x_d  = (x_left < X_MIN_S) ? 10'(X_MIN) : x_left[9:0];
        end
      end else if (mot.keycode_char[7:0] == RIGHT_CODE) begin
        facing_d = 1'b1;
        if (!mot.blocked_right) begin
          moving_d = 1'b1;
          pos_x_d  = (x_right > X_MAX_S) ? 10'(X_MAX) : x_right[9:0];
        end
      end

      case (state_q)
        ST_GROUND: begin
          if (mot.keycode_char[15:8] == UP_CODE) begin
            vy_d    = 8'(-JUMP_V0);
            state_d = ST_RISE;
          end else if (!mot.on_ground) begin
            vy_d    = '0;
            state_d = ST_FALL;
          end
        end
        ST_RISE: begin
          if (mot.hit_ceiling) begin
            vy_d    = '0;
            state_d = ST_FALL;
          end else begin
            pos_y_d = (y_sum < 11'sd0) ? 10'd0 : y_sum[9:0];
            vy_d    = vy_inc[7:0];
            if (!vy_inc[10]) state_d = ST_FALL;
          end
        end
        ST_FALL: begin
          if (mot.on_ground) begin
            vy_d    = '0;
            state_d = ST_GROUND;
          end else if (y_sum >= Y_MAX_S) begin
            pos_y_d = 10'(Y_MAX);
            vy_d    = '0;
            state_d = ST_GROUND;
          end else begin
            pos_y_d = y_sum[9:0];
            vy_d    = (vy_inc > VMAX_S) ? 8'(VMAX_FALL) : vy_inc[7:0];
          end
        end
        default: begin
          vy_d    = '0;
          state_d = ST_GROUND;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_q  <= 10'(X_START);
      pos_y_q  <= 10'(Y_START);
      vy_q     <= '0;
      state_q  <= ST_GROUND;
      facing_q <= 1'b1;
      moving_q <= 1'b0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vy_q     <= vy_d;
      state_q  <= state_d;
      facing_q <= facing_d;
      moving_q <= moving_d;
    end
  end

  assign mot.pos_x        = pos_x_q;
  assign mot.pos_y        = pos_y_q;
  assign mot.facing       = facing_q;
  assign mot.motion_state = state_q;
  assign mot.moving       = moving_q;

endmodule

// File: tb/tb_character_motion.sv
// Bench for character_motion: per-cycle comparison against a frame-level
// behavioural model, plus literal checkpoints along the directed scenario.
module tb_character_motion;

  logic Clk;
  logic Reset_n;
  logic frame_clk;

  character_motion_if bus ();

  character_motion dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .mot       (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model state, advanced once per frame using plain integer physics.
  typedef struct packed {
    int x; int y; int vy; int st; int face; int mov;
  } mstate_t;

  mstate_t    m;
  logic [3:0] fc_hist;

  function automatic mstate_t reset_state();
    mstate_t r;
    r.x = 32; r.y = 400; r.vy = 0; r.st = 0; r.face = 1; r.mov = 0;
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [15:0] kc,
                                   input bit bl, input bit br, input bit og, input bit hc);
    mstate_t n = s;
    n.mov = 0;
    if (kc[7:0] == 8'h04) begin
      n.face = 0;
      if (!bl) begin n.mov = 1; n.x = (s.x - 2 < 16) ? 16 : s.x - 2; end
    end else if (kc[7:0] == 8'h07) begin
      n.face = 1;
      if (!br) begin n.mov = 1; n.x = (s.x + 2 > 608) ? 608 : s.x + 2; end
    end
    case (s.st)
      0: begin
        if (kc[15:8] == 8'h1a) begin n.vy = -12; n.st = 1; end
        else if (!og) begin n.vy = 0; n.st = 2; end
      end
      1: begin
        if (hc) begin n.vy = 0; n.st = 2; end
        else begin
          n.y  = (s.y + s.vy < 0) ? 0 : s.y + s.vy;
          n.vy = s.vy + 1;
          if (n.vy >= 0) n.st = 2;
        end
      end
      default: begin
        if (og) begin n.vy = 0; n.st = 0; end
        else if (s.y + s.vy >= 448) begin n.y = 448; n.vy = 0; n.st = 0; end
        else begin n.y = s.y + s.vy; n.vy = (s.vy + 1 > 8) ? 8 : s.vy + 1; end
      end
    endcase
    return n;
  endfunction

  // A frame rise sampled at edge N takes effect at edge N+3.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m       <= reset_state();
      fc_hist <= '0;
    end else begin
      fc_hist <= {fc_hist[2:0], frame_clk};
      if (fc_hist[2] && !fc_hist[3])
        m <= step(m, bus.keycode_char, bus.blocked_left, bus.blocked_right,
                  bus.on_ground, bus.hit_ceiling);
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cyc_pos_x",  int'(bus.pos_x),        m.x);
      check("cyc_pos_y",  int'(bus.pos_y),        m.y);
      check("cyc_state",  int'(bus.motion_state), m.st);
      check("cyc_facing", int'(bus.facing),       m.face);
      check("cyc_moving", int'(bus.moving),       m.mov);
    end
  end

  task automatic frame_tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset_n = 1'b0;
    @(negedge Clk) Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic set_in(input logic [15:0] kc, input bit og);
    bus.keycode_char = kc;
    bus.on_ground    = og;
  endtask

  initial begin
    int falls;
    int prev_x;
    int changes;
    int first_idx;

    Reset_n = 1'b0;
    frame_clk = 1'b0;
    bus.keycode_char  = 16'h0000;
    bus.blocked_left  = 1'b0;
    bus.blocked_right = 1'b0;
    bus.on_ground     = 1'b1;
    bus.hit_ceiling   = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    cmp_en = 1'b1;

    // Reset held: frame pulses must not move anything.
    set_in(16'h0007, 1'b1);
    repeat (3) frame_tick();
    check("rst_pos_x", int'(bus.pos_x), 32);
    check("rst_pos_y", int'(bus.pos_y), 400);
    check("rst_state", int'(bus.motion_state), 0);
    check("rst_facing", int'(bus.facing), 1);
    check("rst_moving", int'(bus.moving), 0);
    set_in(16'h0000, 1'b1);
    @(negedge Clk) Reset_n = 1'b1;
    @(negedge Clk);

    // Walk right, then left into the X_MIN clamp.
    set_in(16'h0007, 1'b1);
    repeat (10) frame_tick();
    check("walk_r_x", int'(bus.pos_x), 52);
    check("walk_r_face", int'(bus.facing), 1);
    check("walk_r_mov", int'(bus.moving), 1);
    check("model_walk_x", m.x, 52);
    set_in(16'h0004, 1'b1);
    repeat (20) frame_tick();
    check("walk_l_x", int'(bus.pos_x), 16);
    check("walk_l_face", int'(bus.facing), 0);

    // Blocked right: turn around without moving.
    set_in(16'h0007, 1'b1);
    bus.blocked_right = 1'b1;
    frame_tick();
    check("wall_x", int'(bus.pos_x), 16);
    check("wall_face", int'(bus.facing), 1);
    check("wall_mov", int'(bus.moving), 0);
    bus.blocked_right = 1'b0;

    // Full jump arc ending on the Y_MAX floor clamp.
    set_in(16'h0000, 1'b1);
    do_reset();
    set_in(16'h1a00, 1'b1);
    frame_tick();
    check("jump_state", int'(bus.motion_state), 1);
    check("jump_y", int'(bus.pos_y), 400);
    check("model_jump_vy", m.vy, -12);
    set_in(16'h0000, 1'b0);
    repeat (12) frame_tick();
    check("apex_y", int'(bus.pos_y), 322);
    check("apex_state", int'(bus.motion_state), 2);
    falls = 0;
    while (bus.motion_state != 2'd0 && falls < 40) begin
      frame_tick();
      falls++;
    end
    check("fall_ticks", falls, 21);
    check("land_y", int'(bus.pos_y), 448);
    check("land_state", int'(bus.motion_state), 0);

    // Ceiling hit mid-rise.
    set_in(16'h0000, 1'b1);
    do_reset();
    set_in(16'h1a00, 1'b1);
    frame_tick();
    set_in(16'h0000, 1'b0);
    repeat (3) frame_tick();
    check("ceil_pre_y", int'(bus.pos_y), 367);
    bus.hit_ceiling = 1'b1;
    frame_tick();
    check("ceil_y", int'(bus.pos_y), 367);
    check("ceil_state", int'(bus.motion_state), 2);
    bus.hit_ceiling = 1'b0;
    frame_tick();
    check("ceil_next_y", int'(bus.pos_y), 367);
    set_in(16'h0000, 1'b1);
    frame_tick();
    check("ceil_ground", int'(bus.motion_state), 0);

    // frame_clk held high: exactly one update, three edges after sampling.
    do_reset();
    set_in(16'h0007, 1'b1);
    prev_x = int'(bus.pos_x);
    changes = 0;
    first_idx = 0;
    @(negedge Clk) frame_clk = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge Clk);
      if (int'(bus.pos_x) != prev_x) begin
        changes++;
        if (first_idx == 0) first_idx = i;
        prev_x = int'(bus.pos_x);
      end
    end
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    check("hold_changes", changes, 1);
    check("hold_latency", first_idx, 4);
    check("hold_x", int'(bus.pos_x), 34);

    // Asynchronous reset in the middle of a rise.
    set_in(16'h1a00, 1'b1);
    frame_tick();
    set_in(16'h0000, 1'b0);
    frame_tick();
    check("mid_rise_y", int'(bus.pos_y), 388);
    @(negedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    check("arst_x", int'(bus.pos_x), 32);
    check("arst_y", int'(bus.pos_y), 400);
    check("arst_state", int'(bus.motion_state), 0);
    check("arst_facing", int'(bus.facing), 1);
    @(negedge Clk) Reset_n = 1'b1;
    set_in(16'h0000, 1'b1);
    frame_tick();
    check("post_rst_y", int'(bus.pos_y), 400);
    check("post_rst_state", int'(bus.motion_state), 0);
    set_in(16'h0007, 1'b1);
    frame_tick();
    check("post_rst_x", int'(bus.pos_x), 34);

    cmp_en = 1'b0;
    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
